// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the MEM stage.
// Accepts one load/store per valid/ready handshake and holds it for LATENCY
// cycles. It then commits or reads word storage and pulses rsp_valid for one
// cycle. While an access is outstanding, mem_stall freezes the pipeline.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   stateIdle  | no access outstanding, ready for a request
//   stateWait  | access captured, latency down-counter running
//   stateResp  | response cycle; a new request may be accepted here
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_stall
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] stateIdle = 2'd0;
    localparam logic [1:0] stateWait = 2'd1;
    localparam logic [1:0] stateResp = 2'd2;

    // Counter reload so that the access lands exactly LATENCY edges after acceptance.
    localparam logic [3:0]  latReload  = 4'(LATENCY - 1);
    localparam logic [29:0] depthWords = 30'(DEPTH);

    logic [1:0]       state;
    logic [3:0]       latCount;
    logic             capWrite;
    logic [31:0]      capAddr;
    logic [31:0]      capWdata;
    logic [31:0]      rspRdata;
    logic             rspErr;
    logic [31:0]      mem [DEPTH];

    logic             accept;
    logic             accessNow;
    logic             accessErr;
    logic             memWrite;
    logic [IDX_W-1:0] wordIdx;

    // Handshake and status decode, all from state plus the live request.
    always_comb begin
        req_ready = (state != stateWait);
        accept    = req_valid & req_ready;
        mem_stall = (state == stateWait) | accept;
        rsp_valid = (state == stateResp);
        accessNow = (state == stateWait) && (latCount == 4'd0);
        accessErr = (capAddr[1:0] != 2'b00) || (capAddr[31:2] >= depthWords);
        wordIdx   = capAddr[IDX_W+1:2];
        // A commit edge that coincides with reset must not touch storage.
        memWrite  = accessNow & capWrite & ~accessErr & ~rst;
    end

    assign rsp_rdata = rspRdata;
    assign rsp_err   = rspErr;

    // Request capture, latency timer and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= stateIdle;
            latCount <= 4'd0;
            capWrite <= 1'b0;
            capAddr  <= 32'd0;
            capWdata <= 32'd0;
            rspRdata <= 32'd0;
            rspErr   <= 1'b0;
        end else begin
            case (state)
                stateIdle, stateResp: begin
                    if (accept) begin
                        capWrite <= req_write;
                        capAddr  <= req_addr;
                        capWdata <= req_wdata;
                        latCount <= latReload;
                        state    <= stateWait;
                    end else begin
                        state    <= stateIdle;
                    end
                end
                stateWait: begin
                    if (latCount != 4'd0) begin
                        latCount <= latCount - 4'd1;
                    end else begin
                        state  <= stateResp;
                        rspErr <= accessErr;
                        if (accessErr || capWrite) begin
                            rspRdata <= 32'd0;
                        end else begin
                            rspRdata <= mem[wordIdx];
                        end
                    end
                end
                default: begin
                    state <= stateIdle;
                end
            endcase
        end
    end

    // Word storage; deliberately not reset so committed data survives a reset.
    always_ff @(posedge clk) begin
        if (memWrite) begin
            mem[wordIdx] <= capWdata;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance for the main tests
// and a LATENCY=1 instance for the short-latency case.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        reqValid = 1'b0, reqWrite = 1'b0;
    logic [31:0] reqAddr = 32'd0, reqWdata = 32'd0;
    logic        reqReady, rspValid, rspErr, memStall;
    logic [31:0] rspRdata;

    logic        v1 = 1'b0, w1 = 1'b0;
    logic [31:0] a1 = 32'd0, d1 = 32'd0;
    logic        rdy1, rv1, re1, st1;
    logic [31:0] rd1;

    int nVec  = 0;
    int nFail = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(256), .LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(reqValid), .req_ready(reqReady), .req_write(reqWrite),
        .req_addr(reqAddr), .req_wdata(reqWdata),
        .rsp_valid(rspValid), .rsp_rdata(rspRdata), .rsp_err(rspErr),
        .mem_stall(memStall)
    );

    dmem_responder #(.DEPTH(256), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(v1), .req_ready(rdy1), .req_write(w1),
        .req_addr(a1), .req_wdata(d1),
        .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(re1),
        .mem_stall(st1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
        reqValid = 1'b1; reqWrite = w; reqAddr = a; reqWdata = d;
        tick();
        reqValid = 1'b0; reqWrite = 1'b0; reqAddr = 32'd0; reqWdata = 32'd0;
    endtask

    // Edges after acceptance until rsp_valid is seen; -1 on timeout.
    task automatic waitRsp(output int lat);
        lat = 0;
        while (rspValid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        if (rspValid !== 1'b1) lat = -1;
    endtask

    task automatic doOp(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic err, output int lat);
        issue(w, a, d);
        waitRsp(lat);
        rd  = rspRdata;
        err = rspErr;
    endtask

    task automatic test_reset();
        rst = 1'b1; reqValid = 1'b0;
        repeat (2) tick();
        nVec++; if (rspValid !== 1'b0) begin nFail++; $display("FAIL rst_valid: got %b expected 0", rspValid); end
        nVec++; if (rspRdata !== 32'd0) begin nFail++; $display("FAIL rst_rdata: got %h expected 00000000", rspRdata); end
        nVec++; if (rspErr !== 1'b0) begin nFail++; $display("FAIL rst_err: got %b expected 0", rspErr); end
        nVec++; if (reqReady !== 1'b1) begin nFail++; $display("FAIL rst_ready: got %b expected 1", reqReady); end
        nVec++; if (memStall !== 1'b0) begin nFail++; $display("FAIL rst_stall_idle: got %b expected 0", memStall); end
        reqValid = 1'b1; reqAddr = 32'h10;
        #1;
        nVec++; if (memStall !== 1'b1) begin nFail++; $display("FAIL rst_stall_follows_valid: got %b expected 1", memStall); end
        tick();
        reqValid = 1'b0; reqAddr = 32'd0;
        #1;
        nVec++; if (reqReady !== 1'b1) begin nFail++; $display("FAIL rst_wins_ready: got %b expected 1", reqReady); end
        nVec++; if (memStall !== 1'b0) begin nFail++; $display("FAIL rst_wins_stall: got %b expected 0", memStall); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_store_load();
        issue(1'b1, 32'h10, 32'hDEADBEEF);
        nVec++; if (memStall !== 1'b1) begin nFail++; $display("FAIL sl_stall_w0: got %b expected 1", memStall); end
        nVec++; if (reqReady !== 1'b0) begin nFail++; $display("FAIL sl_ready_w0: got %b expected 0", reqReady); end
        nVec++; if (rspValid !== 1'b0) begin nFail++; $display("FAIL sl_valid_w0: got %b expected 0", rspValid); end
        tick();
        nVec++; if (memStall !== 1'b1) begin nFail++; $display("FAIL sl_stall_w1: got %b expected 1", memStall); end
        nVec++; if (rspValid !== 1'b0) begin nFail++; $display("FAIL sl_valid_w1: got %b expected 0", rspValid); end
        tick();
        nVec++; if (rspValid !== 1'b1) begin nFail++; $display("FAIL sl_store_rsp: got %b expected 1", rspValid); end
        nVec++; if (rspErr !== 1'b0) begin nFail++; $display("FAIL sl_store_err: got %b expected 0", rspErr); end
        nVec++; if (rspRdata !== 32'd0) begin nFail++; $display("FAIL sl_store_rdata: got %h expected 00000000", rspRdata); end
        reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 32'h10;
        #1;
        nVec++; if (reqReady !== 1'b1) begin nFail++; $display("FAIL sl_ready_resp: got %b expected 1", reqReady); end
        nVec++; if (memStall !== 1'b1) begin nFail++; $display("FAIL sl_stall_accept: got %b expected 1", memStall); end
        tick();
        reqValid = 1'b0; reqAddr = 32'd0;
        nVec++; if (rspValid !== 1'b0) begin nFail++; $display("FAIL sl_pulse_width: got %b expected 0", rspValid); end
        nVec++; if (memStall !== 1'b1) begin nFail++; $display("FAIL sl_stall_lw0: got %b expected 1", memStall); end
        tick();
        nVec++; if (memStall !== 1'b1) begin nFail++; $display("FAIL sl_stall_lw1: got %b expected 1", memStall); end
        tick();
        nVec++; if (rspValid !== 1'b1) begin nFail++; $display("FAIL sl_load_rsp: got %b expected 1", rspValid); end
        nVec++; if (rspRdata !== 32'hDEADBEEF) begin nFail++; $display("FAIL sl_load_rdata: got %h expected deadbeef", rspRdata); end
        nVec++; if (rspErr !== 1'b0) begin nFail++; $display("FAIL sl_load_err: got %b expected 0", rspErr); end
        tick();
        nVec++; if (rspValid !== 1'b0) begin nFail++; $display("FAIL sl_idle_valid: got %b expected 0", rspValid); end
        nVec++; if (memStall !== 1'b0) begin nFail++; $display("FAIL sl_idle_stall: got %b expected 0", memStall); end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic        er;
        int          lat;
        doOp(1'b1, 32'h0, 32'h11111111, rd, er, lat);
        nVec++; if (er !== 1'b0) begin nFail++; $display("FAIL err_store0_err: got %b expected 0", er); end
        doOp(1'b1, 32'h3FC, 32'hCAFEF00D, rd, er, lat);
        nVec++; if (er !== 1'b0) begin nFail++; $display("FAIL err_store3fc_err: got %b expected 0", er); end
        doOp(1'b0, 32'h3FC, 32'h0, rd, er, lat);
        nVec++; if (rd !== 32'hCAFEF00D) begin nFail++; $display("FAIL err_load3fc_pre: got %h expected cafef00d", rd); end
        doOp(1'b0, 32'h13, 32'h0, rd, er, lat);
        nVec++; if (er !== 1'b1) begin nFail++; $display("FAIL err_misalign_err: got %b expected 1", er); end
        nVec++; if (rd !== 32'd0) begin nFail++; $display("FAIL err_misalign_rdata: got %h expected 00000000", rd); end
        nVec++; if (lat !== 2) begin nFail++; $display("FAIL err_misalign_lat: got %0d expected 2", lat); end
        doOp(1'b1, 32'h400, 32'hBAD0BAD0, rd, er, lat);
        nVec++; if (er !== 1'b1) begin nFail++; $display("FAIL err_range_err: got %b expected 1", er); end
        nVec++; if (rd !== 32'd0) begin nFail++; $display("FAIL err_range_rdata: got %h expected 00000000", rd); end
        doOp(1'b1, 32'h2, 32'hFFFFFFFF, rd, er, lat);
        nVec++; if (er !== 1'b1) begin nFail++; $display("FAIL err_mis_store_err: got %b expected 1", er); end
        doOp(1'b0, 32'h3FC, 32'h0, rd, er, lat);
        nVec++; if (rd !== 32'hCAFEF00D) begin nFail++; $display("FAIL err_load3fc_post: got %h expected cafef00d", rd); end
        nVec++; if (er !== 1'b0) begin nFail++; $display("FAIL err_load3fc_err: got %b expected 0", er); end
        doOp(1'b0, 32'h0, 32'h0, rd, er, lat);
        nVec++; if (rd !== 32'h11111111) begin nFail++; $display("FAIL err_word0_intact: got %h expected 11111111", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [31:0] addrs [3];
        logic [31:0] vals  [3];
        addrs = '{32'h0, 32'h4, 32'h8};
        vals  = '{32'd1, 32'd2, 32'd3};
        for (int i = 0; i < 3; i++) begin
            doOp(1'b1, addrs[i], vals[i], rd, er, lat);
            nVec++; if (lat !== 2) begin nFail++; $display("FAIL b2b_store_lat[%0d]: got %0d expected 2", i, lat); end
            nVec++; if (rd !== 32'd0 || er !== 1'b0) begin nFail++; $display("FAIL b2b_store_rsp[%0d]: got rdata %h err %b expected 00000000 0", i, rd, er); end
        end
        for (int i = 0; i < 3; i++) begin
            doOp(1'b0, addrs[i], 32'h0, rd, er, lat);
            nVec++; if (lat !== 2) begin nFail++; $display("FAIL b2b_load_lat[%0d]: got %0d expected 2", i, lat); end
            nVec++; if (rd !== vals[i]) begin nFail++; $display("FAIL b2b_load_data[%0d]: got %h expected %h", i, rd, vals[i]); end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          seen;
        doOp(1'b1, 32'h20, 32'hAA, rd, er, lat);
        nVec++; if (er !== 1'b0) begin nFail++; $display("FAIL rm_pre_store_err: got %b expected 0", er); end
        tick();
        issue(1'b1, 32'h20, 32'h55);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nVec++; if (reqReady !== 1'b1) begin nFail++; $display("FAIL rm_ready_after_rst: got %b expected 1", reqReady); end
        seen = 0;
        repeat (4) begin
            if (rspValid !== 1'b0) seen++;
            tick();
        end
        nVec++; if (seen !== 0) begin nFail++; $display("FAIL rm_no_rsp: got %0d responses expected 0", seen); end
        doOp(1'b0, 32'h20, 32'h0, rd, er, lat);
        nVec++; if (rd !== 32'hAA) begin nFail++; $display("FAIL rm_load_old: got %h expected 000000aa", rd); end
        tick();
    endtask

    task automatic test_latency1();
        v1 = 1'b1; w1 = 1'b1; a1 = 32'h8; d1 = 32'h77;
        tick();
        v1 = 1'b0; w1 = 1'b0; a1 = 32'd0; d1 = 32'd0;
        nVec++; if (rv1 !== 1'b0 || st1 !== 1'b1) begin nFail++; $display("FAIL l1_store_wait: got valid %b stall %b expected 0 1", rv1, st1); end
        tick();
        nVec++; if (rv1 !== 1'b1 || re1 !== 1'b0) begin nFail++; $display("FAIL l1_store_rsp: got valid %b err %b expected 1 0", rv1, re1); end
        tick();
        v1 = 1'b1; w1 = 1'b0; a1 = 32'h8;
        tick();
        nVec++; if (rdy1 !== 1'b0 || rv1 !== 1'b0 || st1 !== 1'b1) begin nFail++; $display("FAIL l1_load_wait: got ready %b valid %b stall %b expected 0 0 1", rdy1, rv1, st1); end
        tick();
        v1 = 1'b0; a1 = 32'd0;
        nVec++; if (rv1 !== 1'b1) begin nFail++; $display("FAIL l1_load_rsp: got %b expected 1", rv1); end
        nVec++; if (rd1 !== 32'h77 || re1 !== 1'b0) begin nFail++; $display("FAIL l1_load_data: got %h err %b expected 00000077 0", rd1, re1); end
        tick();
        nVec++; if (rv1 !== 1'b0 || st1 !== 1'b0) begin nFail++; $display("FAIL l1_no_second: got valid %b stall %b expected 0 0", rv1, st1); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_latency1();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule
